// File: rtl/sdf_pkg.sv
// Shared constants and state encoding for the SDF FFT frame scheduler.
package sdf_pkg;

    localparam int WIDTH_DEFAULT    = 16;
    localparam int LOG_N_DEFAULT    = 6;
    localparam int OUT_SKIP_DEFAULT = 63;

    // Width of the in-flight frame counter; it saturates at its all-ones value.
    localparam int FP_W = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/sdf_frame_counter.sv
// Modulo-N sample counter with a single-cycle wrap pulse on the N-1 -> 0 step.
module sdf_frame_counter
    import sdf_pkg::*;
#(
    parameter int LOG_N = LOG_N_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [LOG_N-1:0] cnt_o,
    output logic             wrap_o
);

    logic [LOG_N-1:0] cnt_q;

    // Advance once per enabled cycle; natural binary overflow gives the modulo-N wrap.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + LOG_N'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = en_i && (cnt_q == '1);

endmodule

// File: rtl/sdf_frame_scheduler.sv
// Gates a valid/ready sample stream into the SDF pipeline, pads/drains on flush,
// and tags pipeline outputs with frame start/end.
module sdf_frame_scheduler
    import sdf_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEFAULT,
    parameter int LOG_N    = LOG_N_DEFAULT,
    parameter int OUT_SKIP = OUT_SKIP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_re_i,
    input  logic [WIDTH-1:0] s_im_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             fft_en_o,
    output logic [WIDTH-1:0] fft_re_o,
    output logic [WIDTH-1:0] fft_im_o,
    input  logic             fft_out_en_i,
    input  logic [WIDTH-1:0] fft_out_re_i,
    input  logic [WIDTH-1:0] fft_out_im_i,
    output logic             m_valid_o,
    output logic             m_sof_o,
    output logic             m_eof_o,
    output logic [WIDTH-1:0] m_re_o,
    output logic [WIDTH-1:0] m_im_o
);

    // One full frame of drain samples; pad counts above this are still frame padding.
    localparam logic [LOG_N:0] PAD_DRAIN = (LOG_N+1)'(1 << LOG_N);
    localparam logic [LOG_N:0] SKIP      = (LOG_N+1)'(OUT_SKIP);

    state_e           state_q, state_d;
    logic [LOG_N:0]   pad_cnt_q, pad_cnt_d;
    logic             s_ready_q;
    logic             fft_en_q;
    logic [WIDTH-1:0] fft_re_q, fft_im_q;
    logic [LOG_N:0]   skip_cnt_q;
    logic [FP_W-1:0]  fp_q;
    logic             m_valid_q, m_sof_q, m_eof_q;
    logic [WIDTH-1:0] m_re_q, m_im_q;

    logic             xfer, in_flush, in_adv, drain;
    logic [LOG_N-1:0] in_cnt, in_next, in_rem;
    logic             in_wrap;
    logic             skip_done, out_adv, accept;
    logic [LOG_N-1:0] out_cnt;
    logic             out_wrap;
    logic             fp_inc, fp_dec;

    assign xfer     = s_valid_i && s_ready_q;
    assign in_flush = (state_q == ST_FLUSH);
    assign in_adv   = xfer || in_flush;
    // Wraps during the drain frame carry no data and must not create a pending frame.
    assign drain    = in_flush && (pad_cnt_q <= PAD_DRAIN);

    sdf_frame_counter #(.LOG_N(LOG_N)) u_in_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (in_adv),
        .cnt_o  (in_cnt),
        .wrap_o (in_wrap)
    );

    // Position after a same-cycle transfer, so a flush sees that sample counted.
    assign in_next = in_cnt + {{(LOG_N-1){1'b0}}, xfer};
    assign in_rem  = '0 - in_next;

    // Next-state logic: flush in RUN loads pad + drain length; FLUSH counts it down.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        pad_cnt_d = pad_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (flush_i) begin
                    state_d   = ST_FLUSH;
                    pad_cnt_d = {1'b0, in_rem} + PAD_DRAIN;
                end
            end
            ST_FLUSH: begin
                pad_cnt_d = pad_cnt_q - (LOG_N+1)'(1);
                if (pad_cnt_q == (LOG_N+1)'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State register; s_ready is low while in reset and rises on the first clock after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            pad_cnt_q <= '0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pad_cnt_q <= pad_cnt_d;
            s_ready_q <= (state_d == ST_RUN);
        end
    end

    // Pipeline feed: accepted sample or a zero pad/drain sample, one cycle after the decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fft_en_q <= 1'b0;
            fft_re_q <= '0;
            fft_im_q <= '0;
        end else begin
            fft_en_q <= in_adv;
            fft_re_q <= xfer ? s_re_i : '0;
            fft_im_q <= xfer ? s_im_i : '0;
        end
    end

    assign skip_done = (skip_cnt_q == SKIP);
    assign out_adv   = fft_out_en_i && skip_done;
    assign accept    = out_adv && (fp_q != '0);

    sdf_frame_counter #(.LOG_N(LOG_N)) u_out_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (out_adv),
        .cnt_o  (out_cnt),
        .wrap_o (out_wrap)
    );

    // Drop the pipeline-fill pulses that follow reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_cnt_q <= '0;
        end else if (fft_out_en_i && !skip_done) begin
            skip_cnt_q <= skip_cnt_q + (LOG_N+1)'(1);
        end
    end

    assign fp_inc = in_wrap && !drain;
    assign fp_dec = accept && out_wrap;

    // Frames in flight: +1 per completed input frame, -1 per emitted eof, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fp_q <= '0;
        end else begin
            case ({fp_inc, fp_dec})
                2'b10:   if (fp_q != '1) fp_q <= fp_q + FP_W'(1);
                2'b01:   fp_q <= fp_q - FP_W'(1);
                default: fp_q <= fp_q;
            endcase
        end
    end

    // Tagged output stage, registered one cycle after the pipeline pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_sof_q   <= 1'b0;
            m_eof_q   <= 1'b0;
            m_re_q    <= '0;
            m_im_q    <= '0;
        end else begin
            m_valid_q <= accept;
            m_sof_q   <= accept && (out_cnt == '0);
            m_eof_q   <= accept && out_wrap;
            m_re_q    <= accept ? fft_out_re_i : '0;
            m_im_q    <= accept ? fft_out_im_i : '0;
        end
    end

    assign s_ready_o = s_ready_q;
    assign busy_o    = in_flush || (fp_q != '0) || (in_cnt != '0);
    assign fft_en_o  = fft_en_q;
    assign fft_re_o  = fft_re_q;
    assign fft_im_o  = fft_im_q;
    assign m_valid_o = m_valid_q;
    assign m_sof_o   = m_sof_q;
    assign m_eof_o   = m_eof_q;
    assign m_re_o    = m_re_q;
    assign m_im_o    = m_im_q;

endmodule

// File: tb/tb_sdf_frame_scheduler.sv
// Self-checking bench for sdf_frame_scheduler: a frame-level reference model plus
// a short delay line standing in for the SDF pipeline.
module tb_sdf_frame_scheduler;

    localparam int WIDTH    = 16;
    localparam int LOG_N    = 6;
    localparam int N        = 1 << LOG_N;
    localparam int OUT_SKIP = 63;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] s_re = '0, s_im = '0;
    logic             flush = 1'b0;
    logic             busy;
    logic             fft_en;
    logic [WIDTH-1:0] fft_re, fft_im;
    logic             fft_out_en;
    logic [WIDTH-1:0] fft_out_re, fft_out_im;
    logic             m_valid, m_sof, m_eof;
    logic [WIDTH-1:0] m_re, m_im;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sdf_frame_scheduler #(.WIDTH(WIDTH), .LOG_N(LOG_N), .OUT_SKIP(OUT_SKIP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .s_re_i       (s_re),
        .s_im_i       (s_im),
        .flush_i      (flush),
        .busy_o       (busy),
        .fft_en_o     (fft_en),
        .fft_re_o     (fft_re),
        .fft_im_o     (fft_im),
        .fft_out_en_i (fft_out_en),
        .fft_out_re_i (fft_out_re),
        .fft_out_im_i (fft_out_im),
        .m_valid_o    (m_valid),
        .m_sof_o      (m_sof),
        .m_eof_o      (m_eof),
        .m_re_o       (m_re),
        .m_im_o       (m_im)
    );

    // Stand-in pipeline: every fft_en pulse reappears as fft_out_en two cycles later.
    logic [1:0]       p_en;
    logic [WIDTH-1:0] p_re0, p_re1, p_im0, p_im1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_en  <= '0;
            p_re0 <= '0; p_re1 <= '0;
            p_im0 <= '0; p_im1 <= '0;
        end else begin
            p_en  <= {p_en[0], fft_en};
            p_re0 <= fft_re; p_re1 <= p_re0;
            p_im0 <= fft_im; p_im1 <= p_im0;
        end
    end
    assign fft_out_en = p_en[1];
    assign fft_out_re = p_re1;
    assign fft_out_im = p_im1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: totals of samples and frames, not per-block counters.
    int m_in_total, m_flush_left, m_data_frames, m_out_frames, m_out_pulses, m_pos;
    logic m_xfer, m_drain;
    logic e_ready, e_fft_en, e_m_valid, e_sof, e_eof, e_busy;
    logic [WIDTH-1:0] e_fft_re, e_fft_im, e_m_re, e_m_im;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_in_total = 0; m_flush_left = 0; m_data_frames = 0;
                m_out_frames = 0; m_out_pulses = 0;
                e_ready = 1'b0; e_fft_en = 1'b0; e_fft_re = '0; e_fft_im = '0;
                e_m_valid = 1'b0; e_sof = 1'b0; e_eof = 1'b0; e_m_re = '0; e_m_im = '0;
                e_busy = 1'b0;
            end else begin
                // Output side: a frame may be tagged once its whole input frame was taken.
                e_m_valid = 1'b0; e_sof = 1'b0; e_eof = 1'b0;
                if (fft_out_en) begin
                    if (m_out_pulses >= OUT_SKIP) begin
                        m_pos = (m_out_pulses - OUT_SKIP) % N;
                        if (m_data_frames > m_out_frames) begin
                            e_m_valid = 1'b1;
                            e_sof     = (m_pos == 0);
                            e_eof     = (m_pos == N - 1);
                            e_m_re    = fft_out_re;
                            e_m_im    = fft_out_im;
                            if (m_pos == N - 1) m_out_frames++;
                        end
                    end
                    m_out_pulses++;
                end
                // Input side: accepted samples, then pad and drain zeros after a flush.
                m_xfer   = s_valid && e_ready;
                m_drain  = (m_flush_left > 0) && (m_flush_left <= N);
                e_fft_en = m_xfer || (m_flush_left > 0);
                e_fft_re = m_xfer ? s_re : '0;
                e_fft_im = m_xfer ? s_im : '0;
                if (e_fft_en) begin
                    m_in_total++;
                    if ((m_in_total % N == 0) && !m_drain) m_data_frames++;
                end
                if (m_flush_left > 0) m_flush_left--;
                else if (flush) m_flush_left = (N - m_in_total % N) % N + N;
                e_ready = (m_flush_left == 0);
                e_busy  = (m_flush_left > 0) || (m_data_frames != m_out_frames) ||
                          (m_in_total % N != 0);
            end
        end
    end

    // Compare process and observation counters, sampled on the falling edge.
    int n_mvalid, n_sof, n_eof, n_fft_en, n_zero_en, n_ready_low;
    initial begin
        forever begin
            @(negedge clk);
            check("s_ready", 32'(s_ready), 32'(e_ready));
            check("busy", 32'(busy), 32'(e_busy));
            check("fft_en", 32'(fft_en), 32'(e_fft_en));
            if (e_fft_en) begin
                check("fft_re", 32'(fft_re), 32'(e_fft_re));
                check("fft_im", 32'(fft_im), 32'(e_fft_im));
            end
            check("m_valid", 32'(m_valid), 32'(e_m_valid));
            check("m_sof", 32'(m_sof), 32'(e_sof));
            check("m_eof", 32'(m_eof), 32'(e_eof));
            if (e_m_valid) begin
                check("m_re", 32'(m_re), 32'(e_m_re));
                check("m_im", 32'(m_im), 32'(e_m_im));
            end
            if (m_valid) n_mvalid++;
            if (m_sof) n_sof++;
            if (m_eof) n_eof++;
            if (fft_en) n_fft_en++;
            if (fft_en && fft_re == '0 && fft_im == '0) n_zero_en++;
            if (rst_n && !s_ready) n_ready_low++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_mvalid = 0; n_sof = 0; n_eof = 0; n_fft_en = 0; n_zero_en = 0; n_ready_low = 0;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        flush   = 1'b0;
        rst_n   = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        clear_counts();
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!s_ready && t < 300) begin
            step();
            t++;
        end
        if (!s_ready) check("ready_timeout", 32'(s_ready), 32'd1);
    endtask

    // Sends n samples, each followed by gap idle cycles; samples are never zero.
    task automatic send(input int n, input int gap, input int base);
        for (int i = 0; i < n; i++) begin
            wait_ready();
            s_valid = 1'b1;
            s_re    = WIDTH'(base + i);
            s_im    = WIDTH'(16'h4000 + base + 3 * i);
            step();
            s_valid = 1'b0;
            repeat (gap) step();
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || fft_en || p_en != 2'b00 || m_valid) && t < 600) begin
            step();
            t++;
        end
        check("drain_timeout", 32'(busy), 32'd0);
        repeat (3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        #2;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fft_en", 32'(fft_en), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        do_reset();

        // Back-to-back full frame; last sample pops out as the first tagged output
        send(N, 0, 1);
        repeat (5) step();
        check("t1_fft_en_cnt", 32'(n_fft_en), 32'd64);
        check("t1_ready_low", 32'(n_ready_low), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_first_out", 32'(n_mvalid), 32'd1);
        check("t1_first_sof", 32'(n_sof), 32'd1);

        // Flush after a full frame: drain only, exactly one tagged frame
        n_zero_en = 0; n_ready_low = 0;
        pulse_flush();
        wait_idle();
        check("t2_ready_low", 32'(n_ready_low), 32'd64);
        check("t2_zero_en", 32'(n_zero_en), 32'd64);
        check("t2_mvalid", 32'(n_mvalid), 32'd64);
        check("t2_sof", 32'(n_sof), 32'd1);
        check("t2_eof", 32'(n_eof), 32'd1);

        // Partial frame of 10: 54 pad + 64 drain zeros
        do_reset();
        send(10, 0, 200);
        pulse_flush();
        wait_idle();
        check("t3_ready_low", 32'(n_ready_low), 32'd118);
        check("t3_zero_en", 32'(n_zero_en), 32'd118);
        check("t3_mvalid", 32'(n_mvalid), 32'd64);
        check("t3_eof", 32'(n_eof), 32'd1);

        // Gapped source, one sample in three cycles
        do_reset();
        send(N, 2, 500);
        pulse_flush();
        wait_idle();
        check("t4_fft_en_cnt", 32'(n_fft_en), 32'd128);
        check("t4_mvalid", 32'(n_mvalid), 32'd64);
        check("t4_sof", 32'(n_sof), 32'd1);
        check("t4_eof", 32'(n_eof), 32'd1);

        // Flush together with the 64th sample: frame wraps, pad is drain only
        do_reset();
        send(N - 1, 0, 900);
        wait_ready();
        s_valid = 1'b1;
        s_re    = 16'h0ABC;
        s_im    = 16'h0DEF;
        flush   = 1'b1;
        step();
        s_valid = 1'b0;
        flush   = 1'b0;
        check("t5_busy_in_flush", 32'(busy), 32'd1);
        wait_idle();
        check("t5_ready_low", 32'(n_ready_low), 32'd64);
        check("t5_mvalid", 32'(n_mvalid), 32'd64);
        check("t5_eof", 32'(n_eof), 32'd1);
        check("t5_busy_end", 32'(busy), 32'd0);

        // Reset asserted mid-flush clears outputs asynchronously
        do_reset();
        send(10, 0, 1300);
        pulse_flush();
        repeat (20) step();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_fft_en", 32'(fft_en), 32'd0);
        check("t6_async_fft_re", 32'(fft_re), 32'd0);
        check("t6_async_s_ready", 32'(s_ready), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_m_valid", 32'(m_valid), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        clear_counts();
        check("t6_busy_after", 32'(busy), 32'd0);
        send(N, 0, 1700);
        pulse_flush();
        wait_idle();
        check("t6_mvalid", 32'(n_mvalid), 32'd64);
        check("t6_sof", 32'(n_sof), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
